vga_timing: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 37 +++
 rtl/vga_timing_if.sv | 22 ++
 rtl/vga_axis_counter.sv | 89 ++++++++
 rtl/vga_timing.sv | 102 ++++++++++
 tb/tb_vga_timing.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA raster timing generator: coordinate width and
// the standard display mode tables (800x600@60 and 640x480@60).
package vga_timing_pkg;

  localparam int COORD_W   = 11;
  localparam int COORD_MAX = 2047;

  // 800x600@60, 40 MHz pixel clock, positive syncs
  localparam int SVGA_H_VISIBLE   = 800;
  localparam int SVGA_H_FP        = 40;
  localparam int SVGA_H_SYNC      = 128;
  localparam int SVGA_H_BP        = 88;
  localparam int SVGA_V_VISIBLE   = 600;
  localparam int SVGA_V_FP        = 1;
  localparam int SVGA_V_SYNC      = 4;
  localparam int SVGA_V_BP        = 23;
  localparam bit SVGA_H_SYNC_POL  = 1'b1;
  localparam bit SVGA_V_SYNC_POL  = 1'b1;

  // 640x480@60, 25.175 MHz pixel clock, negative syncs
  localparam int VGA_H_VISIBLE    = 640;
  localparam int VGA_H_FP         = 16;
  localparam int VGA_H_SYNC       = 96;
  localparam int VGA_H_BP         = 48;
  localparam int VGA_V_VISIBLE    = 480;
  localparam int VGA_V_FP         = 10;
  localparam int VGA_V_SYNC       = 2;
  localparam int VGA_V_BP         = 33;
  localparam bit VGA_H_SYNC_POL   = 1'b0;
  localparam bit VGA_V_SYNC_POL   = 1'b0;

  function automatic int axis_total(input int visible, input int fp,
                                    input int sync, input int bp);
    return visible + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Raster position and sync/strobe bundle from vga_timing to the connector
// and to downstream fetch logic (vga_frame).
interface vga_timing_if;
  import vga_timing_pkg::*;

  logic [COORD_W-1:0] vga_h;
  logic [COORD_W-1:0] vga_v;
  logic               hsync;
  logic               vsync;
  logic               active;
  logic               line_start;
  logic               frame_start;

  modport master (
    output vga_h, vga_v, hsync, vsync, active, line_start, frame_start
  );

  modport slave (
    input  vga_h, vga_v, hsync, vsync, active, line_start, frame_start
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with wrap, sync window and visible flag.
// sync is registered from the next count; in_visible describes the next count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int VISIBLE = 800,
  parameter int FP      = 40,
  parameter int SYNC    = 128,
  parameter int BP      = 88,
  parameter bit POL     = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               advance,
  output logic [COORD_W-1:0] count,
  output logic               wrap,
  output logic               sync,
  output logic               in_visible
);

  localparam int TOTAL = axis_total(VISIBLE, FP, SYNC, BP);

  localparam logic [COORD_W-1:0] LAST       = COORD_W'(TOTAL - 1);
  localparam logic [COORD_W-1:0] ZERO       = {COORD_W{1'b0}};
  localparam logic [COORD_W-1:0] ONE        = {{(COORD_W-1){1'b0}}, 1'b1};
  localparam logic [COORD_W-1:0] VIS_END    = COORD_W'(VISIBLE);
  localparam logic [COORD_W-1:0] SYNC_FIRST = COORD_W'(VISIBLE + FP);
  localparam logic [COORD_W-1:0] SYNC_LAST  = COORD_W'(VISIBLE + FP + SYNC - 1);

  if (TOTAL > COORD_MAX) begin : g_total_check
    $error("vga_axis_counter: axis total %0d exceeds %0d", TOTAL, COORD_MAX);
  end

  logic [COORD_W-1:0] count_r;
  logic               sync_r;
  logic [COORD_W-1:0] next_count_s;
  logic               wrap_s;
  logic               next_sync_s;
  logic               in_visible_s;

  // Next position: step on advance, wrap from the last position back to zero
  always_comb begin
    next_count_s = count_r;
    wrap_s       = 1'b0;
    if (advance) begin
      if (count_r == LAST) begin
        next_count_s = ZERO;
        wrap_s       = 1'b1;
      end else begin
        next_count_s = count_r + ONE;
      end
    end else begin
      next_count_s = count_r;
    end
  end

  // Window decode on the next position so flags line up with the count
  always_comb begin
    next_sync_s  = ~POL;
    in_visible_s = 1'b0;
    if ((next_count_s >= SYNC_FIRST) && (next_count_s <= SYNC_LAST)) begin
      next_sync_s = POL;
    end else begin
      next_sync_s = ~POL;
    end
    if (next_count_s < VIS_END) begin
      in_visible_s = 1'b1;
    end else begin
      in_visible_s = 1'b0;
    end
  end

  // Position and sync registers; reset parks on the last blanking position
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= LAST;
      sync_r  <= ~POL;
    end else begin
      count_r <= next_count_s;
      sync_r  <= next_sync_s;
    end
  end

  assign count      = count_r;
  assign wrap       = wrap_s;
  assign sync       = sync_r;
  assign in_visible = in_visible_s;

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing generator: position counters, syncs, active video and
// line/frame strobes. Optional pixel clock-enable under VGA_TIMING_CE_EN.
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE  = SVGA_H_VISIBLE,
  parameter int H_FP       = SVGA_H_FP,
  parameter int H_SYNC     = SVGA_H_SYNC,
  parameter int H_BP       = SVGA_H_BP,
  parameter int V_VISIBLE  = SVGA_V_VISIBLE,
  parameter int V_FP       = SVGA_V_FP,
  parameter int V_SYNC     = SVGA_V_SYNC,
  parameter int V_BP       = SVGA_V_BP,
  parameter bit H_SYNC_POL = SVGA_H_SYNC_POL,
  parameter bit V_SYNC_POL = SVGA_V_SYNC_POL
) (
  input  logic            clk,
  input  logic            reset,
`ifdef VGA_TIMING_CE_EN
  input  logic            pix_ce,
`endif
  vga_timing_if.master    vga
);

  logic               ce_s;
  logic [COORD_W-1:0] h_count_s;
  logic [COORD_W-1:0] v_count_s;
  logic               h_wrap_s;
  logic               v_wrap_s;
  logic               h_sync_s;
  logic               v_sync_s;
  logic               h_visible_s;
  logic               v_visible_s;
  logic               active_r;
  logic               line_start_r;
  logic               frame_start_r;

`ifdef VGA_TIMING_CE_EN
  assign ce_s = pix_ce;
`else
  assign ce_s = 1'b1;
`endif

  vga_axis_counter #(
    .VISIBLE (H_VISIBLE),
    .FP      (H_FP),
    .SYNC    (H_SYNC),
    .BP      (H_BP),
    .POL     (H_SYNC_POL)
  ) u_h_axis (
    .clk        (clk),
    .reset      (reset),
    .advance    (ce_s),
    .count      (h_count_s),
    .wrap       (h_wrap_s),
    .sync       (h_sync_s),
    .in_visible (h_visible_s)
  );

  // The vertical axis only moves on a horizontal wrap, so vsync edges fall on vga_h==0
  vga_axis_counter #(
    .VISIBLE (V_VISIBLE),
    .FP      (V_FP),
    .SYNC    (V_SYNC),
    .BP      (V_BP),
    .POL     (V_SYNC_POL)
  ) u_v_axis (
    .clk        (clk),
    .reset      (reset),
    .advance    (h_wrap_s),
    .count      (v_count_s),
    .wrap       (v_wrap_s),
    .sync       (v_sync_s),
    .in_visible (v_visible_s)
  );

  // Strobes and active video; a wrap means the next position is column/row zero
  always_ff @(posedge clk) begin
    if (reset) begin
      active_r      <= 1'b0;
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
    end else if (ce_s) begin
      active_r      <= h_visible_s & v_visible_s;
      line_start_r  <= h_wrap_s;
      frame_start_r <= h_wrap_s & v_wrap_s;
    end else begin
      active_r      <= active_r;
      line_start_r  <= line_start_r;
      frame_start_r <= frame_start_r;
    end
  end

  assign vga.vga_h       = h_count_s;
  assign vga.vga_v       = v_count_s;
  assign vga.hsync       = h_sync_s;
  assign vga.vsync       = v_sync_s;
  assign vga.active      = active_r;
  assign vga.line_start  = line_start_r;
  assign vga.frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing: default 800x600 instance for reset/line/mid-frame
// checks, plus a tiny-mode instance (25x12, active-low hsync) for full-frame checks.
module tb_vga_timing;
  import vga_timing_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic reset_s = 1'b1;
`ifdef VGA_TIMING_CE_EN
  logic pix_ce = 1'b1;
`endif
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  vga_timing_if vif ();
  vga_timing_if vif_s ();

  vga_timing dut (
    .clk    (clk),
    .reset  (reset),
`ifdef VGA_TIMING_CE_EN
    .pix_ce (pix_ce),
`endif
    .vga    (vif)
  );

  // Small mode: H 16+2+4+3=25 (sync 18..21, active-low), V 6+1+2+3=12 (sync 7..8)
  vga_timing #(
    .H_VISIBLE (16), .H_FP (2), .H_SYNC (4), .H_BP (3),
    .V_VISIBLE (6),  .V_FP (1), .V_SYNC (2), .V_BP (3),
    .H_SYNC_POL (1'b0), .V_SYNC_POL (1'b1)
  ) dut_s (
    .clk    (clk),
    .reset  (reset_s),
`ifdef VGA_TIMING_CE_EN
    .pix_ce (pix_ce),
`endif
    .vga    (vif_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [26:0] obs;
    logic [26:0] exp;
    reset = 1'b1;
    reset_s = 1'b1;
    repeat (3) tick();
    obs = {vif.vga_h, vif.vga_v, vif.hsync, vif.vsync, vif.active, vif.line_start, vif.frame_start};
    exp = {11'd1055, 11'd627, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL reset_hold: got h=%0d v=%0d flags=%b, expected h=%0d v=%0d flags=%b",
               obs[26:16], obs[15:5], obs[4:0], exp[26:16], exp[15:5], exp[4:0]);
    end
    obs = {vif_s.vga_h, vif_s.vga_v, vif_s.hsync, vif_s.vsync, vif_s.active, vif_s.line_start, vif_s.frame_start};
    exp = {11'd24, 11'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL reset_hold_small: got h=%0d v=%0d flags=%b, expected h=%0d v=%0d flags=%b",
               obs[26:16], obs[15:5], obs[4:0], exp[26:16], exp[15:5], exp[4:0]);
    end
    reset = 1'b0;
    reset_s = 1'b0;
    tick();
    obs = {vif.vga_h, vif.vga_v, vif.hsync, vif.vsync, vif.active, vif.line_start, vif.frame_start};
    exp = {11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL reset_release: got h=%0d v=%0d flags=%b, expected h=%0d v=%0d flags=%b",
               obs[26:16], obs[15:5], obs[4:0], exp[26:16], exp[15:5], exp[4:0]);
    end
    obs = {vif_s.vga_h, vif_s.vga_v, vif_s.hsync, vif_s.vsync, vif_s.active, vif_s.line_start, vif_s.frame_start};
    exp = {11'd0, 11'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL reset_release_small: got h=%0d v=%0d flags=%b, expected h=%0d v=%0d flags=%b",
               obs[26:16], obs[15:5], obs[4:0], exp[26:16], exp[15:5], exp[4:0]);
    end
    tick();
    obs = {vif.vga_h, vif.vga_v, vif.hsync, vif.vsync, vif.active, vif.line_start, vif.frame_start};
    exp = {11'd1, 11'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL strobe_one_cycle: got h=%0d v=%0d flags=%b, expected h=%0d v=%0d flags=%b",
               obs[26:16], obs[15:5], obs[4:0], exp[26:16], exp[15:5], exp[4:0]);
    end
  endtask

  // Two full lines on the default mode starting from h=1, v=0
  task automatic test_line_boundary();
    logic [26:0] obs;
    logic [26:0] exp;
    int eh = 1;
    int ev = 0;
    int hs_cycles = 0;
    for (int i = 0; i < 2 * 1056; i++) begin
      tick();
      if (eh == 1055) begin
        eh = 0;
        ev = ev + 1;
      end else begin
        eh = eh + 1;
      end
      exp = {11'(eh), 11'(ev), (eh >= 840 && eh <= 967), 1'b0,
             (eh < 800 && ev < 600), (eh == 0), 1'b0};
      obs = {vif.vga_h, vif.vga_v, vif.hsync, vif.vsync, vif.active, vif.line_start, vif.frame_start};
      if (ev == 1 && vif.hsync === 1'b1) hs_cycles++;
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL line_walk: got h=%0d v=%0d flags=%b, expected h=%0d v=%0d flags=%b",
                 obs[26:16], obs[15:5], obs[4:0], exp[26:16], exp[15:5], exp[4:0]);
      end
    end
    checks++;
    if (hs_cycles !== 128) begin
      failures++;
      $display("FAIL hsync_width: got %0d cycles, expected 128", hs_cycles);
    end
  endtask

  task automatic test_mid_frame_reset();
    logic [26:0] obs;
    logic [26:0] exp;
    int n = 0;
    while (vif.vga_h !== 11'd400 && n < 2000) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 2000) begin
      failures++;
      $display("FAIL reach_h400: got timeout after %0d cycles, expected h=400", n);
    end
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      obs = {vif.vga_h, vif.vga_v, vif.hsync, vif.vsync, vif.active, vif.line_start, vif.frame_start};
      exp = {11'd1055, 11'd627, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL mid_reset_%0d: got h=%0d v=%0d flags=%b, expected h=%0d v=%0d flags=%b",
                 k, obs[26:16], obs[15:5], obs[4:0], exp[26:16], exp[15:5], exp[4:0]);
      end
    end
    reset = 1'b0;
    tick();
    obs = {vif.vga_h, vif.vga_v, vif.hsync, vif.vsync, vif.active, vif.line_start, vif.frame_start};
    exp = {11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL mid_reset_restart: got h=%0d v=%0d flags=%b, expected h=%0d v=%0d flags=%b",
               obs[26:16], obs[15:5], obs[4:0], exp[26:16], exp[15:5], exp[4:0]);
    end
  endtask

  // Two whole frames of the small mode: syncs, blanking, frame period
  task automatic test_vsync_frame();
    logic [26:0] obs;
    logic [26:0] exp;
    int eh = 0;
    int ev = 0;
    int vs_cycles = 0;
    int pulses = 0;
    int last = 0;
    reset_s = 1'b1;
    repeat (2) tick();
    reset_s = 1'b0;
    tick();
    checks++;
    if (vif_s.frame_start !== 1'b1 || vif_s.vga_h !== 11'd0 || vif_s.vga_v !== 11'd0) begin
      failures++;
      $display("FAIL small_restart: got h=%0d v=%0d fs=%b, expected h=0 v=0 fs=1",
               vif_s.vga_h, vif_s.vga_v, vif_s.frame_start);
    end
    for (int i = 1; i <= 600; i++) begin
      tick();
      if (eh == 24) begin
        eh = 0;
        ev = (ev == 11) ? 0 : ev + 1;
      end else begin
        eh = eh + 1;
      end
      exp = {11'(eh), 11'(ev), !(eh >= 18 && eh <= 21), (ev >= 7 && ev <= 8),
             (eh < 16 && ev < 6), (eh == 0), (eh == 0 && ev == 0)};
      obs = {vif_s.vga_h, vif_s.vga_v, vif_s.hsync, vif_s.vsync, vif_s.active, vif_s.line_start, vif_s.frame_start};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL frame_walk: got h=%0d v=%0d flags=%b, expected h=%0d v=%0d flags=%b",
                 obs[26:16], obs[15:5], obs[4:0], exp[26:16], exp[15:5], exp[4:0]);
      end
      if (vif_s.vsync === 1'b1) vs_cycles++;
      if (vif_s.frame_start === 1'b1) begin
        pulses++;
        checks++;
        if (i - last !== 300) begin
          failures++;
          $display("FAIL frame_period: got %0d cycles, expected 300", i - last);
        end
        last = i;
      end
    end
    checks++;
    if (vs_cycles !== 100) begin
      failures++;
      $display("FAIL vsync_width: got %0d cycles over 2 frames, expected 100", vs_cycles);
    end
    checks++;
    if (pulses !== 2) begin
      failures++;
      $display("FAIL frame_pulses: got %0d, expected 2", pulses);
    end
  endtask

`ifdef VGA_TIMING_CE_EN
  task automatic test_pix_ce();
    logic [26:0] obs;
    logic [26:0] exp [0:5];
    logic        ce_seq [0:5];
    logic        rst_seq [0:5];
    exp[0] = {11'd1055, 11'd627, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; ce_seq[0] = 1'b0; rst_seq[0] = 1'b1;
    exp[1] = {11'd1055, 11'd627, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; ce_seq[1] = 1'b0; rst_seq[1] = 1'b0;
    exp[2] = {11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};       ce_seq[2] = 1'b1; rst_seq[2] = 1'b0;
    exp[3] = {11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};       ce_seq[3] = 1'b0; rst_seq[3] = 1'b0;
    exp[4] = {11'd1, 11'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};       ce_seq[4] = 1'b1; rst_seq[4] = 1'b0;
    exp[5] = {11'd1, 11'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};       ce_seq[5] = 1'b0; rst_seq[5] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      pix_ce = ce_seq[k];
      reset = rst_seq[k];
      tick();
      obs = {vif.vga_h, vif.vga_v, vif.hsync, vif.vsync, vif.active, vif.line_start, vif.frame_start};
      checks++;
      if (obs !== exp[k]) begin
        failures++;
        $display("FAIL pix_ce_step%0d: got h=%0d v=%0d flags=%b, expected h=%0d v=%0d flags=%b",
                 k, obs[26:16], obs[15:5], obs[4:0], exp[k][26:16], exp[k][15:5], exp[k][4:0]);
      end
    end
    pix_ce = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_line_boundary();
    test_mid_frame_reset();
    test_vsync_frame();
`ifdef VGA_TIMING_CE_EN
    test_pix_ce();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got simulation still running at 5 ms, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
